// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory responder and its RAM.
package mem_pkg;
    localparam int MEM_ADDR_W = 11;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {PORT_IF, PORT_D} port_t;
    typedef enum logic {ARB_IF_LAST, ARB_D_LAST} arb_t;

    typedef struct packed {
        logic  valid;
        port_t port;
        logic  we;
        logic  err;
    } tag_t;
endpackage

// File: rtl/sram_1p.sv
// sram_1p: single-port synchronous RAM, registered read, old data returned on write.
module sram_1p
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrates fetch and data requests onto one single-port RAM
// and returns tagged responses two cycles after the grant.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_stall,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    arb_t        state_q, state_d;
    tag_t        s1_q, s1_d;
    logic        grant_if, grant_d, any, err;
    logic [31:0] sel_addr;

    // On a collision the port that lost last time wins; IF-last favours data.
    always_comb begin
        grant_d  = d_req & (~if_req | (state_q == ARB_IF_LAST));
        grant_if = if_req & ~grant_d;
        any      = grant_if | grant_d;
        sel_addr = grant_d ? d_addr : if_addr;
        err      = any & ((sel_addr[1:0] != 2'b0) | (sel_addr[31:ADDR_W+2] != '0));
        state_d  = (if_req & d_req) ? (grant_d ? ARB_D_LAST : ARB_IF_LAST) : state_q;
        s1_d     = '{valid: any, port: grant_d ? PORT_D : PORT_IF, we: grant_d & d_we, err: err};
    end

    assign if_stall  = if_req & ~grant_if;
    assign d_stall   = d_req & ~grant_d;
    assign ram_addr  = any ? sel_addr[ADDR_W+1:2] : '0;
    assign ram_we    = grant_d & d_we & ~err;
    assign ram_wdata = d_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IF_LAST;
            s1_q     <= '0;
            if_valid <= 1'b0;
            if_rdata <= '0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            if_valid <= s1_q.valid & (s1_q.port == PORT_IF);
            d_valid  <= s1_q.valid & (s1_q.port == PORT_D);
            if (s1_q.valid && s1_q.port == PORT_IF) begin
                if_rdata <= s1_q.err ? '0 : ram_rdata;
                if_err   <= s1_q.err;
            end
            // Store acks leave the load data register untouched.
            if (s1_q.valid && s1_q.port == PORT_D) begin
                d_err <= s1_q.err;
                if (!s1_q.we) d_rdata <= s1_q.err ? '0 : ram_rdata;
            end
        end
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the ARM32 pipeline. It accepts instruction-fetch requests and data load/store requests from the controller/datapath, arbitrates them onto one single-port synchronous RAM, and returns tagged responses with a fixed 2-cycle latency. That latency lines up with the fetch→fetch_wait→execute and memory→memory_wait→write_back stage pairs. Each port gets a per-port stall when the shared RAM is busy.

## Interface
- ADDR_W, 11, RAM word-address width (RAM depth 2^ADDR_W words)
- DATA_W, 32, data width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, sampled each cycle
- if_addr  in  32  fetch byte address
- if_stall  out  1  fetch not granted this cycle; requester holds if_req/if_addr
- if_valid  out  1  one-cycle pulse: if_rdata/if_err are new
- if_rdata  out  DATA_W  fetched word, held until next fetch response
- if_err  out  1  error flag for this fetch response
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  DATA_W  store data
- d_stall  out  1  data not granted this cycle; requester holds all d_* inputs
- d_valid  out  1  one-cycle pulse: load data or store acknowledge
- d_rdata  out  DATA_W  load word, held; unchanged on store ack
- d_err  out  1  error flag for this data response
- ram_addr  out  ADDR_W  RAM word address (combinational from grant)
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address

## Operation
- Grant, combinational per cycle:
  - Only one port requesting → that port is granted.
  - Both requesting (collision) → the port that lost the previous collision is granted.
  - Register last_winner resets to IF, so data wins the first collision after reset.
- Stalls:
  - if_stall = if_req & ~grant_if.
  - d_stall = d_req & ~grant_d.
  - A stalled port retries in the next cycle with the same inputs.
- FSM arbitration state (last_winner): states ARB_IF_LAST, ARB_D_LAST.
  - The state updates only on a collision; it toggles to the granted port.
  - Non-collision grants leave the state unchanged.
- Address check, for the granted request:
  - err = (addr[1:0] != 0) | (addr[31:ADDR_W+2] != 0).
  - ram_addr = addr[ADDR_W+1:2].
  - ram_we = grant_d & d_we & ~err.
  - ram_wdata = d_wdata.
  - An erroneous store never writes.
- Response pipeline:
  - Stage 1 is registered at the grant edge and holds {valid, port, we, err}.
  - Stage 2 is registered at the following edge and does three things:
    - Pulses if_valid or d_valid for the tagged port.
    - Captures ram_rdata into if_rdata, or into d_rdata for loads only.
    - On err, loads 0 into the rdata register instead.
- Throughput: one grant per cycle, so up to 2 responses are in flight at once.
- Reset values:
  - All valids, errs, rdata registers and stage tags are 0.
  - last_winner = IF.
  - Asserting reset mid-operation drops in-flight responses; no valid pulses until a new grant.
- Idle cycles: ram_we = 0 and ram_addr = 0.

## Timing
- A request granted in cycle t (RAM samples address/we at the end of t):
  - ram_rdata is valid in t+1.
  - The valid pulse and data appear in cycle t+2.
- A store writes at the edge ending cycle t.
- A load in t+1 to the same address returns the new data; there is no read-during-write hazard across cycles.
- A stalled request granted in t+1 responds in t+3.
- Stall outputs are combinational in the same cycle as the request; no registered stall.
- Response ordering per port is preserved.
- Simultaneous stage-2 retire and new stage-1 grant in the same edge is legal.

## Structure
- Shared package mem_pkg holds:
  - Port enum (PORT_IF, PORT_D).
  - Arbitration state enum.
  - Response-tag struct {valid, port, we, err}.
  - Default ADDR_W/DATA_W constants.
- Sub-module: sram_1p. It is a synchronous single-port RAM with registered read (1-cycle latency) and write-first disabled. It sits outside mem_responder and is instantiated beside it at top level; the bench uses it directly.

## Test plan
- Fetch only, if_addr=0x10, RAM[4]=0xE3A01005 → if_stall=0, if_valid pulse at t+2, if_rdata=0xE3A01005, if_err=0.
- First collision after reset: d load 0x40 (RAM[16]=0x11111111) and fetch 0x0 (RAM[0]=0xAAAA0000) in cycle t. Required response:
  - d granted; if_stall=1 in t.
  - d_valid at t+2 with 0x11111111.
  - if_valid at t+3 with 0xAAAA0000.
- Three consecutive collision cycles → grants D, IF, D; stalls alternate; last_winner toggles each time.
- Store 0xDEADBEEF to 0x20 in t, then load 0x20 in t+1:
  - ram_we=1 only in t.
  - d_valid ack at t+2 with d_rdata unchanged.
  - d_valid at t+3 with 0xDEADBEEF.
- Store to 0x22 (misaligned) and load from 0x2000 (out of range for ADDR_W=11) → ram_we stays 0; d_valid with d_err=1 and d_rdata=0 for the load.
- Fetch granted in t, rst_n low during t+1, released in t+2 → no if_valid in any cycle; all outputs 0 during reset.
